fma_issue_scheduler: RTL and testbench
======================================

// Module: fma_issue_scheduler
// PURPOSE
//  Fixed-latency issue scheduler for one FMA slice. Sits between the FP issue queue and the slice.
//  Grants at most one op per cycle, reserving future writeback-port and adder-stage cycles so that
//  ADD, MUL and fused MADD results never collide. Drives the early wakeup and drops reservations
//  of ops killed by a backend redirect.
// PARAMETERS
//  ROB_W        6   ROB index width; MSB is the wrap flag, the rest is the index
//  PREG_W       7   physical register index width
//  ADD_LAT      2   issue-to-writeback cycles, ADD/SUB
//  MUL_LAT      3   issue-to-writeback cycles, MUL
//  MADD_LAT     5   issue-to-writeback cycles, MADD/MSUB/NMADD/NMSUB; sizes the tables (DEPTH=MADD_LAT)
//  MADD_ADD_OFF 3   cycles after MADD issue at which it occupies the shared adder stage
//  WAKE_LEAD    1   wakeup fires this many cycles before writeback
// PORTS
//  clk           in   1       clock
//  rst           in   1       asynchronous reset, active low
//  req_valid     in   1       issue queue presents an op
//  req_op        in   2       00 ADD/SUB, 01 MUL, 10 MADD class, 11 reserved (never granted)
//  req_rob_idx   in   ROB_W   ROB index of the op
//  req_rd        in   PREG_W  destination preg
//  req_ready     out  1       grant; fire = req_valid & req_ready
//  redirect      in   1       backend redirect this cycle
//  redirect_idx  in   ROB_W   redirecting ROB index (kept); strictly younger ops are killed
//  wakeup_en     out  1       dependent-wakeup strobe
//  wakeup_rd     out  PREG_W  preg being woken
//  busy          out  1       any writeback reservation outstanding
//  conflict_cnt  out  16      saturating count of cycles with req_valid & ~req_ready
// BEHAVIOUR
//  Reset (rst=0): both tables cleared; req_ready, wakeup_en, busy = 0; wakeup_rd = 0; conflict_cnt = 0.
//  Tables:
//   - WB table: DEPTH entries {v, rob, rd}. ADD table: DEPTH entries {v, rob}.
//   - Entry i at cycle t denotes an event at cycle t+i.
//   - Every cycle: entry[i] <= entry[i+1]; entry[DEPTH-1] <= 0; entry[0] is consumed.
//  Kill:
//   - younger(a,r) = (a.flag==r.flag) ? (a.idx > r.idx) : (a.idx < r.idx).
//   - While redirect=1, every entry with younger(rob, redirect_idx) is treated invalid in the same
//     cycle (masked view) and is cleared in the next state.
//  Grant (combinational, on the masked view; an index >= DEPTH counts as free):
//   - ADD:  WB[ADD_LAT] free and ADD[0] free (the adder is used in the issue cycle).
//   - MUL:  WB[MUL_LAT] free.
//   - MADD: WB[MADD_LAT] free and ADD[MADD_ADD_OFF] free.
//   - op 11: never granted.
//   - Also no grant if redirect=1 and younger(req_rob_idx, redirect_idx).
//   - req_ready is independent of req_valid, except that op decode uses req_op.
//  On fire:
//   - Write WB[L-1] <= {1, req_rob_idx, req_rd} in the next state (L = op latency).
//   - For MADD, also write ADD[MADD_ADD_OFF-1] <= {1, rob}.
//   - For ADD, no adder write; the offset is 0 and is consumed immediately.
//   - Shift and write happen in the same edge; the written index is never also a shift target
//     of a valid entry (the grant check guarantees this).
//  Wakeup (combinational):
//   - wakeup_en = masked WB[WAKE_LEAD].v; wakeup_rd = WB[WAKE_LEAD].rd (0 when not valid).
//   - For an ADD fired this cycle with ADD_LAT == WAKE_LEAD: wakeup_en=1 and wakeup_rd=req_rd
//     in the fire cycle (bypass).
//  busy: OR of masked WB valid bits.
//  conflict_cnt: +1 per cycle with req_valid & ~req_ready; holds at 16'hFFFF.
//  Simultaneous redirect + fire of an older-or-equal op: the grant proceeds; the kill masks only
//   existing entries.
//  Reset mid-operation: all reservations are dropped immediately; nothing is replayed.
// TESTING
//  1. Reset, then MUL rob=3 rd=9 at t0 -> ready=1; wakeup_en=1 with rd=9 at t0+2; busy is 1 from
//     t0+1 to t0+3 and 0 at t0+4 (the first cycle after the reservation is consumed).
//  2. MADD at t0, ADD at t0+3 -> ADD ready=0 at t0+3 (adder held); ADD at t0+4 -> granted;
//     conflict_cnt=1.
//  3. MADD at t0 (WB at t0+5), MUL at t0+2 (WB at t0+5) -> MUL stalled; MUL at t0+3 -> granted,
//     WB at t0+6.
//  4. MADD rob=0x05 at t0; redirect idx=0x03 at t0+2 -> entry killed, no wakeup at t0+4, busy=0
//     at t0+3. The same case with redirect idx=0x06 -> entry kept.
//  5. Wrap check: entry rob=0x21 (flag=1, idx=1), redirect_idx=0x1E (flag=0, idx=30) -> killed;
//     entry rob=0x1F -> killed; entry rob=0x1D -> kept.
//  6. req_op=11 held valid for 70000 cycles -> never ready; conflict_cnt saturates at 0xFFFF.
//     Assert rst mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fma_issue_scheduler.sv
// Fixed-latency issue scheduler for one FMA slice: reserves writeback-port and shared-adder
// slots ahead of time, drives the early wakeup and drops reservations killed by a redirect.
module fma_issue_scheduler #(
    parameter int ROB_W        = 6,
    parameter int PREG_W       = 7,
    parameter int ADD_LAT      = 2,
    parameter int MUL_LAT      = 3,
    parameter int MADD_LAT     = 5,
    parameter int MADD_ADD_OFF = 3,
    parameter int WAKE_LEAD    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [ROB_W-1:0]  req_rob_idx,
    input  logic [PREG_W-1:0] req_rd,
    output logic              req_ready,
    input  logic              redirect,
    input  logic [ROB_W-1:0]  redirect_idx,
    output logic              wakeup_en,
    output logic [PREG_W-1:0] wakeup_rd,
    output logic              busy,
    output logic [15:0]       conflict_cnt
);

    localparam int DEPTH = MADD_LAT;

    localparam logic [1:0] OpAdd  = 2'b00;
    localparam logic [1:0] OpMul  = 2'b01;
    localparam logic [1:0] OpMadd = 2'b10;

    logic [DEPTH-1:0]  wb_v_q, wb_v_d;
    logic [ROB_W-1:0]  wb_rob_q [DEPTH];
    logic [ROB_W-1:0]  wb_rob_d [DEPTH];
    logic [PREG_W-1:0] wb_rd_q  [DEPTH];
    logic [PREG_W-1:0] wb_rd_d  [DEPTH];
    logic [DEPTH-1:0]  add_v_q, add_v_d;
    logic [ROB_W-1:0]  add_rob_q [DEPTH];
    logic [ROB_W-1:0]  add_rob_d [DEPTH];
    logic [15:0]       cnt_q, cnt_d;

    logic [DEPTH-1:0]  wb_vm, add_vm;
    logic [DEPTH:0]    wb_vx, add_vx;
    logic              grant, fire;

    // Wrap flag in the MSB: a differing flag inverts the index comparison.
    function automatic logic younger(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] r);
        if (a[ROB_W-1] == r[ROB_W-1]) begin
            return a[ROB_W-2:0] > r[ROB_W-2:0];
        end
        return a[ROB_W-2:0] < r[ROB_W-2:0];
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wb_vm[i]  = wb_v_q[i] & ~(redirect & younger(wb_rob_q[i], redirect_idx));
            add_vm[i] = add_v_q[i] & ~(redirect & younger(add_rob_q[i], redirect_idx));
        end
        // Extra always-free top slot so offsets equal to DEPTH read as free.
        wb_vx  = {1'b0, wb_vm};
        add_vx = {1'b0, add_vm};
    end

    always_comb begin
        grant = 1'b0;
        case (req_op)
            OpAdd:   grant = ~wb_vx[ADD_LAT] & ~add_vx[0];
            OpMul:   grant = ~wb_vx[MUL_LAT];
            OpMadd:  grant = ~wb_vx[MADD_LAT] & ~add_vx[MADD_ADD_OFF];
            default: grant = 1'b0;
        endcase
        if (redirect && younger(req_rob_idx, redirect_idx)) begin
            grant = 1'b0;
        end
        req_ready = grant & rst;
        fire      = req_valid & req_ready;
    end

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            wb_v_d[i]    = wb_vm[i+1];
            wb_rob_d[i]  = wb_rob_q[i+1];
            wb_rd_d[i]   = wb_rd_q[i+1];
            add_v_d[i]   = add_vm[i+1];
            add_rob_d[i] = add_rob_q[i+1];
        end
        wb_v_d[DEPTH-1]    = 1'b0;
        wb_rob_d[DEPTH-1]  = '0;
        wb_rd_d[DEPTH-1]   = '0;
        add_v_d[DEPTH-1]   = 1'b0;
        add_rob_d[DEPTH-1] = '0;
        if (fire) begin
            case (req_op)
                OpAdd: begin
                    wb_v_d[ADD_LAT-1]   = 1'b1;
                    wb_rob_d[ADD_LAT-1] = req_rob_idx;
                    wb_rd_d[ADD_LAT-1]  = req_rd;
                end
                OpMul: begin
                    wb_v_d[MUL_LAT-1]   = 1'b1;
                    wb_rob_d[MUL_LAT-1] = req_rob_idx;
                    wb_rd_d[MUL_LAT-1]  = req_rd;
                end
                OpMadd: begin
                    wb_v_d[MADD_LAT-1]          = 1'b1;
                    wb_rob_d[MADD_LAT-1]        = req_rob_idx;
                    wb_rd_d[MADD_LAT-1]         = req_rd;
                    add_v_d[MADD_ADD_OFF-1]     = 1'b1;
                    add_rob_d[MADD_ADD_OFF-1]   = req_rob_idx;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wakeup_en = wb_vm[WAKE_LEAD];
        wakeup_rd = wb_vm[WAKE_LEAD] ? wb_rd_q[WAKE_LEAD] : '0;
        if (ADD_LAT == WAKE_LEAD && fire && req_op == OpAdd) begin
            wakeup_en = 1'b1;
            wakeup_rd = req_rd;
        end
        busy = |wb_vm;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (req_valid && !req_ready && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign conflict_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_v_q  <= '0;
            add_v_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wb_rob_q[i]  <= '0;
                wb_rd_q[i]   <= '0;
                add_rob_q[i] <= '0;
            end
        end else begin
            wb_v_q  <= wb_v_d;
            add_v_q <= add_v_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                wb_rob_q[i]  <= wb_rob_d[i];
                wb_rd_q[i]   <= wb_rd_d[i];
                add_rob_q[i] <= add_rob_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fma_issue_scheduler.sv
// Scoreboard bench: a cycle-keyed reservation model predicts every output each cycle and a
// negedge monitor compares the DUT against the queued predictions.
module tb_fma_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [5:0]  req_rob_idx = '0;
    logic [6:0]  req_rd = '0;
    logic        req_ready;
    logic        redirect = 1'b0;
    logic [5:0]  redirect_idx = '0;
    logic        wakeup_en;
    logic [6:0]  wakeup_rd;
    logic        busy;
    logic [15:0] conflict_cnt;

    always #5 clk = ~clk;

    fma_issue_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_rob_idx  (req_rob_idx),
        .req_rd       (req_rd),
        .req_ready    (req_ready),
        .redirect     (redirect),
        .redirect_idx (redirect_idx),
        .wakeup_en    (wakeup_en),
        .wakeup_rd    (wakeup_rd),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    typedef struct {
        logic        ready;
        logic        wen;
        logic [6:0]  wrd;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: reservations keyed by absolute cycle number.
    bit         m_wb[int];
    logic [5:0] m_wb_rob[int];
    logic [6:0] m_wb_rd[int];
    bit         m_add[int];
    logic [5:0] m_add_rob[int];
    int         now = 0;
    int         m_cnt = 0;

    // Younger means a lies 1..31 steps ahead of r on the 64-entry wrapping ROB ring.
    function automatic bit is_younger(input logic [5:0] a, input logic [5:0] r);
        int d;
        d = (int'(a) - int'(r)) & 63;
        return (d >= 1) && (d <= 31);
    endfunction

    task automatic step(input bit v, input logic [1:0] op, input logic [5:0] rob,
                        input logic [6:0] rd, input bit redir, input logic [5:0] ridx,
                        input bit rn);
        exp_t e;
        int   lat;
        bit   rdy;
        @(posedge clk);
        #1;
        rst = rn; req_valid = v; req_op = op; req_rob_idx = rob; req_rd = rd;
        redirect = redir; redirect_idx = ridx;
        e = '{ready: 1'b0, wen: 1'b0, wrd: '0, busy: 1'b0, cnt: '0};
        if (!rn) begin
            m_wb.delete(); m_wb_rob.delete(); m_wb_rd.delete();
            m_add.delete(); m_add_rob.delete();
            m_cnt = 0;
        end else begin
            if (redir) begin
                for (int k = now; k < now + 8; k++) begin
                    if (m_wb.exists(k) && is_younger(m_wb_rob[k], ridx)) m_wb.delete(k);
                    if (m_add.exists(k) && is_younger(m_add_rob[k], ridx)) m_add.delete(k);
                end
            end
            lat = 0;
            case (op)
                2'b00: begin lat = 2; rdy = !m_wb.exists(now + 2) && !m_add.exists(now); end
                2'b01: begin lat = 3; rdy = !m_wb.exists(now + 3); end
                2'b10: begin
                    lat = 5;
                    rdy = !m_wb.exists(now + 5) && !m_add.exists(now + 3);
                end
                default: rdy = 1'b0;
            endcase
            if (redir && is_younger(rob, ridx)) rdy = 1'b0;
            e.ready = rdy;
            e.wen   = m_wb.exists(now + 1);
            e.wrd   = e.wen ? m_wb_rd[now + 1] : 7'd0;
            for (int k = now; k < now + 5; k++) begin
                if (m_wb.exists(k)) e.busy = 1'b1;
            end
            e.cnt = m_cnt[15:0];
            if (v && !rdy && m_cnt < 65535) m_cnt++;
            if (v && rdy) begin
                m_wb[now + lat] = 1'b1;
                m_wb_rob[now + lat] = rob;
                m_wb_rd[now + lat] = rd;
                if (op == 2'b10) begin
                    m_add[now + 3] = 1'b1;
                    m_add_rob[now + 3] = rob;
                end
            end
        end
        exp_q.push_back(e);
        now++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 6'd0, 7'd0, 1'b0, 6'd0, 1'b1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] rob, input logic [6:0] rd);
        step(1'b1, op, rob, rd, 1'b0, 6'd0, 1'b1);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req_ready", 16'(req_ready), 16'(e.ready));
            chk("wakeup_en", 16'(wakeup_en), 16'(e.wen));
            chk("wakeup_rd", 16'(wakeup_rd), 16'(e.wrd));
            chk("busy", 16'(busy), 16'(e.busy));
            chk("conflict_cnt", conflict_cnt, e.cnt);
        end
    end

    initial begin
        logic [1:0] op;
        int         sel;
        step(1'b0, 2'b00, 6'd0, 7'd0, 1'b0, 6'd0, 1'b0);
        step(1'b0, 2'b00, 6'd0, 7'd0, 1'b0, 6'd0, 1'b0);
        idle(2);

        // MUL latency, wakeup lead and busy window
        issue(2'b01, 6'd3, 7'd9);
        idle(6);

        // MADD holds the shared adder three cycles after issue
        issue(2'b10, 6'd1, 7'd10);
        idle(2);
        issue(2'b00, 6'd2, 7'd11);
        issue(2'b00, 6'd2, 7'd11);
        idle(6);

        // Writeback-port collision between MADD and MUL
        issue(2'b10, 6'd4, 7'd12);
        idle(1);
        issue(2'b01, 6'd5, 7'd13);
        issue(2'b01, 6'd5, 7'd13);
        idle(7);

        // Redirect kills a younger MADD, keeps it against a younger redirect index
        issue(2'b10, 6'h05, 7'd20);
        idle(1);
        step(1'b0, 2'b00, 6'd0, 7'd0, 1'b1, 6'h03, 1'b1);
        idle(6);
        issue(2'b10, 6'h05, 7'd21);
        idle(1);
        step(1'b0, 2'b00, 6'd0, 7'd0, 1'b1, 6'h06, 1'b1);
        idle(6);

        // Wrap-flag age comparison
        issue(2'b01, 6'h1D, 7'd30);
        issue(2'b10, 6'h21, 7'd31);
        issue(2'b00, 6'h1F, 7'd32);
        step(1'b0, 2'b00, 6'd0, 7'd0, 1'b1, 6'h1E, 1'b1);
        idle(6);
        issue(2'b01, 6'h1D, 7'd33);
        issue(2'b10, 6'h21, 7'd34);
        step(1'b0, 2'b00, 6'd0, 7'd0, 1'b1, 6'h1E, 1'b1);
        idle(6);

        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            op  = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            step($urandom_range(0, 3) != 0, op, 6'($urandom), 7'($urandom),
                 $urandom_range(0, 9) == 0, 6'($urandom), $urandom_range(0, 499) != 0);
        end
        idle(6);

        // Reserved op never granted; counter saturates; reset drops everything at once
        step(1'b0, 2'b00, 6'd0, 7'd0, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b1, 2'b11, 6'd0, 7'd0, 1'b0, 6'd0, 1'b1);
        step(1'b1, 2'b11, 6'd0, 7'd0, 1'b0, 6'd0, 1'b0);
        step(1'b1, 2'b11, 6'd0, 7'd0, 1'b0, 6'd0, 1'b0);
        step(1'b1, 2'b11, 6'd0, 7'd0, 1'b0, 6'd0, 1'b1);
        idle(3);

        @(negedge clk);
        #1;
        chk("scoreboard_drain", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
